output_buffer: RTL and testbench

Parametrised result buffer at the output of the systolic array. Captures one row of COLS accumulator results per write beat until a full ROWS x COLS frame is held. The frame can then be read out two ways:
- random-access reads with a fixed one-cycle latency;
- a valid/ready streaming drain in row-major order.

The buffer supersedes the fixed 16-entry read-only output memory.

---
 rtl/output_buffer_pkg.sv | 20 ++
 rtl/output_buffer_if.sv | 42 ++++
 rtl/output_buffer_storage.sv | 64 ++++++
 rtl/output_buffer.sv | 113 +++++++++++
 tb/tb_output_buffer.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/output_buffer_pkg.sv
// Shared types and default geometry for the systolic-array output buffer.
package output_buffer_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } obuf_state_e;

  localparam int OBUF_DATA_W = 33;
  localparam int OBUF_ROWS   = 4;
  localparam int OBUF_COLS   = 4;

  // Index width that stays legal (>=1 bit) for a single-entry dimension.
  function automatic int obuf_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/output_buffer_if.sv
// Write, random-read and drain signal bundle of the output buffer.
interface output_buffer_if
  import output_buffer_pkg::*;
#(
  parameter int DATA_W = OBUF_DATA_W,
  parameter int ROWS   = OBUF_ROWS,
  parameter int COLS   = OBUF_COLS
);

  localparam int DEPTH  = ROWS * COLS;
  localparam int ADDR_W = obuf_idx_w(DEPTH);

  logic                     clear;
  logic                     wr_valid;
  logic [COLS*DATA_W-1:0]   wr_data;
  logic                     wr_ready;
  logic                     frame_done;
  logic                     rd_en;
  logic [ADDR_W-1:0]        rd_addr;
  logic [DATA_W-1:0]        rd_data;
  logic                     rd_valid;
  logic                     drain_start;
  logic                     drain_valid;
  logic                     drain_ready;
  logic [DATA_W-1:0]        drain_data;
  logic                     drain_last;
  logic                     busy;
  logic                     overflow;

  modport slave (
    input  clear, wr_valid, wr_data, rd_en, rd_addr, drain_start, drain_ready,
    output wr_ready, frame_done, rd_data, rd_valid, drain_valid, drain_data,
           drain_last, busy, overflow
  );

  modport master (
    output clear, wr_valid, wr_data, rd_en, rd_addr, drain_start, drain_ready,
    input  wr_ready, frame_done, rd_data, rd_valid, drain_valid, drain_data,
           drain_last, busy, overflow
  );

endinterface

// File: rtl/output_buffer_storage.sv
// ROWS x COLS element store: row-wide write, registered random read,
// combinational drain read, synchronous zeroing on clear.
module obuf_storage
  import output_buffer_pkg::*;
#(
  parameter int DATA_W = OBUF_DATA_W,
  parameter int ROWS   = OBUF_ROWS,
  parameter int COLS   = OBUF_COLS
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  clear,
  input  logic                                  wr_en,
  input  logic [obuf_idx_w(ROWS)-1:0]           wr_row,
  input  logic [COLS*DATA_W-1:0]                wr_data,
  input  logic                                  rd_en,
  input  logic [obuf_idx_w(ROWS*COLS)-1:0]      rd_addr,
  output logic [DATA_W-1:0]                     rd_data,
  output logic                                  rd_valid,
  input  logic [obuf_idx_w(ROWS*COLS)-1:0]      dr_addr,
  output logic [DATA_W-1:0]                     dr_data
);

  localparam int DEPTH  = ROWS * COLS;
  localparam int ROW_W  = obuf_idx_w(ROWS);
  localparam int ADDR_W = obuf_idx_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_p1;
  logic              rd_vld_p1;
  logic              rd_in_range;

  // Flat row-major array; a write beat lands on the COLS entries of one row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < DEPTH; e++) mem[e] <= '0;
    end else if (clear) begin
      for (int e = 0; e < DEPTH; e++) mem[e] <= '0;
    end else if (wr_en) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (wr_row == ROW_W'(e / COLS))
          mem[e] <= wr_data[(e % COLS)*DATA_W +: DATA_W];
      end
    end
  end

  assign rd_in_range = ({1'b0, rd_addr} < (ADDR_W+1)'(DEPTH));

  // ---- stage p1: random read (samples pre-write contents) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_p1 <= '0;
      rd_vld_p1  <= 1'b0;
    end else begin
      rd_vld_p1 <= rd_en;
      if (rd_en) rd_data_p1 <= rd_in_range ? mem[rd_addr] : '0;
    end
  end

  assign rd_data  = rd_data_p1;
  assign rd_valid = rd_vld_p1;
  assign dr_data  = mem[dr_addr];

endmodule

// File: rtl/output_buffer.sv
// Frame buffer behind the systolic array: fills row-per-beat, then serves
// random reads and a row-major valid/ready drain.
module output_buffer
  import output_buffer_pkg::*;
#(
  parameter int DATA_W = OBUF_DATA_W,
  parameter int ROWS   = OBUF_ROWS,
  parameter int COLS   = OBUF_COLS
) (
  input  logic             clk,
  input  logic             rst_n,
  output_buffer_if.slave   bus
);

  localparam int DEPTH  = ROWS * COLS;
  localparam int ROW_W  = obuf_idx_w(ROWS);
  localparam int ADDR_W = obuf_idx_w(DEPTH);

  obuf_state_e       state, state_nxt;
  logic [ROW_W-1:0]  wr_ptr, wr_ptr_nxt;
  logic [ADDR_W-1:0] drain_ptr, drain_ptr_nxt;
  logic              frame_done_q, frame_done_nxt;
  logic              overflow_q, overflow_nxt;
  logic              wr_ready, wr_fire, last_row;
  logic              drain_valid, drain_fire, last_elem;
  logic [DATA_W-1:0] dr_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= EMPTY;
      wr_ptr       <= '0;
      drain_ptr    <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state        <= state_nxt;
      wr_ptr       <= wr_ptr_nxt;
      drain_ptr    <= drain_ptr_nxt;
      frame_done_q <= frame_done_nxt;
      overflow_q   <= overflow_nxt;
    end
  end

  always_comb begin
    wr_ready       = (state == EMPTY) || (state == FILL);
    drain_valid    = (state == DRAIN);
    wr_fire        = bus.wr_valid && wr_ready && !bus.clear;
    drain_fire     = drain_valid && bus.drain_ready && !bus.clear;
    last_row       = (wr_ptr == ROW_W'(ROWS - 1));
    last_elem      = (drain_ptr == ADDR_W'(DEPTH - 1));
    state_nxt      = state;
    wr_ptr_nxt     = wr_ptr;
    drain_ptr_nxt  = drain_ptr;
    frame_done_nxt = 1'b0;
    overflow_nxt   = overflow_q || (bus.wr_valid && !wr_ready);

    if (wr_fire) begin
      wr_ptr_nxt     = last_row ? '0 : wr_ptr + 1'b1;
      frame_done_nxt = last_row;
    end
    if (drain_fire) drain_ptr_nxt = last_elem ? '0 : drain_ptr + 1'b1;

    // EMPTY with ROWS=1 sees last_row true and skips FILL.
    unique case (state)
      EMPTY:   if (wr_fire) state_nxt = last_row ? FULL : FILL;
      FILL:    if (wr_fire && last_row) state_nxt = FULL;
      FULL: begin
        if (bus.drain_start) begin
          state_nxt     = DRAIN;
          drain_ptr_nxt = '0;
        end
      end
      DRAIN:   if (drain_fire && last_elem) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase

    if (bus.clear) begin
      state_nxt      = EMPTY;
      wr_ptr_nxt     = '0;
      drain_ptr_nxt  = '0;
      frame_done_nxt = 1'b0;
      overflow_nxt   = 1'b0;
    end
  end

  obuf_storage #(
    .DATA_W (DATA_W),
    .ROWS   (ROWS),
    .COLS   (COLS)
  ) u_storage (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (bus.clear),
    .wr_en    (wr_fire),
    .wr_row   (wr_ptr),
    .wr_data  (bus.wr_data),
    .rd_en    (bus.rd_en),
    .rd_addr  (bus.rd_addr),
    .rd_data  (bus.rd_data),
    .rd_valid (bus.rd_valid),
    .dr_addr  (drain_ptr),
    .dr_data  (dr_data)
  );

  assign bus.wr_ready    = wr_ready;
  assign bus.frame_done  = frame_done_q;
  assign bus.drain_valid = drain_valid;
  assign bus.drain_data  = dr_data;
  assign bus.drain_last  = drain_valid && last_elem;
  assign bus.busy        = (state == FILL) || (state == DRAIN);
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_output_buffer.sv
// Directed scoreboard bench for output_buffer: default 4x4, a 3x4 build and a 16-bit 2x8 build.
`timescale 1ns/1ps
module tb_output_buffer;

  localparam int AW = 33, AR = 4, AC = 4, AD = AR*AC;
  localparam int BW = 33, BR = 3, BC = 4;
  localparam int CW = 16, CR = 2, CC = 8, CD = CR*CC;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  output_buffer_if #(.DATA_W(AW), .ROWS(AR), .COLS(AC)) a_if();
  output_buffer_if #(.DATA_W(BW), .ROWS(BR), .COLS(BC)) b_if();
  output_buffer_if #(.DATA_W(CW), .ROWS(CR), .COLS(CC)) c_if();

  output_buffer #(.DATA_W(AW), .ROWS(AR), .COLS(AC)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  output_buffer #(.DATA_W(BW), .ROWS(BR), .COLS(BC)) u_b (.clk(clk), .rst_n(rst_n), .bus(b_if));
  output_buffer #(.DATA_W(CW), .ROWS(CR), .COLS(CC)) u_c (.clk(clk), .rst_n(rst_n), .bus(c_if));

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] model_a [AD];
  logic [AW-1:0] rd_q    [$];
  logic [AW-1:0] drain_q [$];
  logic [CW-1:0] drain_c [$];
  logic [AW-1:0] last_rd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rd_a(input int addr);
    a_if.rd_en   = 1'b1;
    a_if.rd_addr = 4'(addr);
    rd_q.push_back((addr < AD) ? model_a[addr] : '0);
  endtask

  // One clock; checks the A random-read port against the scoreboard.
  task automatic step();
    logic          rv_exp;
    logic [AW-1:0] exp;
    rv_exp = a_if.rd_en;
    @(posedge clk);
    #1;
    a_if.rd_en = 1'b0;
    chk("a_rd_valid", a_if.rd_valid, rv_exp);
    if (rv_exp) begin
      exp = '1;
      if (rd_q.size() > 0) exp = rd_q.pop_front();
      last_rd = exp;
    end
    chk("a_rd_data", a_if.rd_data, last_rd);
  endtask

  task automatic fill_a(input int kind);
    logic [AW-1:0] val;
    for (int r = 0; r < AR; r++) begin
      for (int c = 0; c < AC; c++) begin
        val = (kind == 0) ? AW'(r*16 + c + 1) : {1'b1, 32'(r*AC + c)};
        a_if.wr_data[c*AW +: AW] = val;
        model_a[r*AC + c] = val;
      end
      a_if.wr_valid = 1'b1;
      a_if.drain_start = (r == AR-1);
      chk("fill_wr_ready", a_if.wr_ready, 1);
      step();
      chk("fill_frame_done", a_if.frame_done, (r == AR-1));
      chk("fill_busy", a_if.busy, (r != AR-1));
    end
    a_if.wr_valid    = 1'b0;
    a_if.drain_start = 1'b0;
    step();
    chk("frame_done_once", a_if.frame_done, 0);
    chk("full_wr_ready", a_if.wr_ready, 0);
    chk("full_no_drain", a_if.drain_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] bv;
    logic [CW-1:0] cv;
    int cyc;

    a_if.clear = 0; a_if.wr_valid = 0; a_if.wr_data = '0; a_if.rd_en = 0; a_if.rd_addr = '0;
    a_if.drain_start = 0; a_if.drain_ready = 0;
    b_if.clear = 0; b_if.wr_valid = 0; b_if.wr_data = '0; b_if.rd_en = 0; b_if.rd_addr = '0;
    b_if.drain_start = 0; b_if.drain_ready = 0;
    c_if.clear = 0; c_if.wr_valid = 0; c_if.wr_data = '0; c_if.rd_en = 0; c_if.rd_addr = '0;
    c_if.drain_start = 0; c_if.drain_ready = 0;
    for (int e = 0; e < AD; e++) model_a[e] = '0;
    last_rd = '0;

    // Reset state
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_wr_ready", a_if.wr_ready, 1);
    chk("rst_frame_done", a_if.frame_done, 0);
    chk("rst_rd_valid", a_if.rd_valid, 0);
    chk("rst_rd_data", a_if.rd_data, 0);
    chk("rst_drain_valid", a_if.drain_valid, 0);
    chk("rst_drain_last", a_if.drain_last, 0);
    chk("rst_busy", a_if.busy, 0);
    chk("rst_overflow", a_if.overflow, 0);
    #9 rst_n = 1'b1;

    // drain_start in EMPTY is ignored
    a_if.drain_start = 1'b1;
    step();
    a_if.drain_start = 1'b0;
    chk("empty_drain_ignored", a_if.drain_valid, 0);
    chk("empty_busy", a_if.busy, 0);

    fill_a(0);

    // Random reads, back to back, then hold
    rd_a(0);  step();
    rd_a(5);  step();
    rd_a(10); step();
    rd_a(15); step();
    step();

    // Beat while FULL is dropped, overflow sticky
    a_if.wr_valid = 1'b1;
    a_if.wr_data  = '1;
    step();
    a_if.wr_valid = 1'b0;
    chk("overflow_set", a_if.overflow, 1);
    step();
    chk("overflow_sticky", a_if.overflow, 1);

    // Drain with drain_ready toggling and a concurrent random read
    a_if.drain_start = 1'b1;
    step();
    a_if.drain_start = 1'b0;
    chk("drain_busy", a_if.busy, 1);
    for (int e = 0; e < AD; e++) drain_q.push_back(model_a[e]);
    cyc = 0;
    while (drain_q.size() > 0 && cyc < 100) begin
      a_if.drain_ready = (cyc % 2 == 0);
      if (cyc == 3) rd_a(3);
      chk("drain_valid", a_if.drain_valid, 1);
      chk("drain_data", a_if.drain_data, drain_q[0]);
      chk("drain_last", a_if.drain_last, (drain_q.size() == 1));
      if (a_if.drain_ready) void'(drain_q.pop_front());
      step();
      cyc++;
    end
    a_if.drain_ready = 1'b0;
    chk("drain_remaining", drain_q.size(), 0);
    chk("drain_end_valid", a_if.drain_valid, 0);
    chk("drain_end_busy", a_if.busy, 0);
    chk("drain_end_wr_ready", a_if.wr_ready, 1);
    chk("drain_keeps_overflow", a_if.overflow, 1);
    rd_a(15); step();

    // clear: beat discarded, read in the clear cycle sees old data
    a_if.clear    = 1'b1;
    a_if.wr_valid = 1'b1;
    a_if.wr_data  = '1;
    rd_a(5);
    step();
    a_if.clear    = 1'b0;
    a_if.wr_valid = 1'b0;
    for (int e = 0; e < AD; e++) model_a[e] = '0;
    chk("clear_overflow", a_if.overflow, 0);
    chk("clear_beat_dropped", a_if.busy, 0);
    chk("clear_wr_ready", a_if.wr_ready, 1);
    rd_a(0);  step();
    rd_a(5);  step();
    rd_a(15); step();

    // Async reset in the middle of a drain
    fill_a(1);
    a_if.drain_start = 1'b1;
    step();
    a_if.drain_start = 1'b0;
    a_if.drain_ready = 1'b1;
    for (int e = 0; e < 7; e++) begin
      chk("rdrain_data", a_if.drain_data, model_a[e]);
      step();
    end
    a_if.drain_ready = 1'b0;
    chk("rdrain_elem7", a_if.drain_data, model_a[7]);
    #2 rst_n = 1'b0;
    #1;
    for (int e = 0; e < AD; e++) model_a[e] = '0;
    last_rd = '0;
    rd_q.delete();
    chk("arst_drain_valid", a_if.drain_valid, 0);
    chk("arst_busy", a_if.busy, 0);
    chk("arst_rd_data", a_if.rd_data, 0);
    chk("arst_wr_ready", a_if.wr_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    rd_a(7);  step();
    rd_a(15); step();

    // ROWS=3 build: frame after 3 beats, out-of-range addresses read 0
    for (int r = 0; r < BR; r++) begin
      for (int c = 0; c < BC; c++) b_if.wr_data[c*BW +: BW] = BW'(32'h200 + r*BC + c);
      b_if.wr_valid = 1'b1;
      step();
      chk("b_frame_done", b_if.frame_done, (r == BR-1));
    end
    b_if.wr_valid = 1'b0;
    b_if.rd_en = 1'b1;
    b_if.rd_addr = 4'd11;
    step();
    chk("b_rd_valid_11", b_if.rd_valid, 1);
    chk("b_rd_11", b_if.rd_data, 33'h20B);
    b_if.rd_addr = 4'd12;
    step();
    chk("b_rd_valid_12", b_if.rd_valid, 1);
    chk("b_rd_12", b_if.rd_data, 0);
    b_if.rd_addr = 4'd15;
    step();
    chk("b_rd_15", b_if.rd_data, 0);
    b_if.rd_en = 1'b0;
    step();
    chk("b_rd_valid_off", b_if.rd_valid, 0);

    // DATA_W=16, ROWS=2, COLS=8 build
    for (int r = 0; r < CR; r++) begin
      for (int c = 0; c < CC; c++) begin
        cv = 16'(16'hC000 + (r*CC + c) * 16'h0101);
        c_if.wr_data[c*CW +: CW] = cv;
        drain_c.push_back(cv);
      end
      c_if.wr_valid = 1'b1;
      step();
      chk("c_frame_done", c_if.frame_done, (r == CR-1));
    end
    c_if.wr_valid = 1'b0;
    c_if.drain_start = 1'b1;
    step();
    c_if.drain_start = 1'b0;
    c_if.drain_ready = 1'b1;
    cyc = 0;
    while (drain_c.size() > 0 && cyc < CD + 8) begin
      chk("c_drain_valid", c_if.drain_valid, 1);
      chk("c_drain_data", c_if.drain_data, drain_c[0]);
      chk("c_drain_last", c_if.drain_last, (drain_c.size() == 1));
      void'(drain_c.pop_front());
      step();
      cyc++;
    end
    c_if.drain_ready = 1'b0;
    chk("c_drain_remaining", drain_c.size(), 0);
    chk("c_drain_end", c_if.drain_valid, 0);
    bv = '0;
    chk("b_idle_overflow", b_if.overflow, bv);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
